// File: rtl/fetch_stage_pkg.sv
// Shared constants and payload types for the fetch stage: reset PC default,
// branch opcode and B-type immediate field positions.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [6:0]      OPCODE_BRANCH    = 7'b1100011;

  localparam int unsigned OPC_MSB     = 6;
  localparam int unsigned OPC_LSB     = 0;
  localparam int unsigned BIMM_SIGN   = 31;
  localparam int unsigned BIMM_B11    = 7;
  localparam int unsigned BIMM_HI_MSB = 30;
  localparam int unsigned BIMM_HI_LSB = 25;
  localparam int unsigned BIMM_LO_MSB = 11;
  localparam int unsigned BIMM_LO_LSB = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface fetch_stage_if;
  logic        fetch_o_req_valid;
  logic [31:0] fetch_o_req_addr;
  logic        imem_i_req_ready;
  logic        imem_i_rsp_valid;
  logic [31:0] imem_i_rsp_inst;

  modport master (
    output fetch_o_req_valid, fetch_o_req_addr,
    input  imem_i_req_ready, imem_i_rsp_valid, imem_i_rsp_inst
  );

  modport slave (
    input  fetch_o_req_valid, fetch_o_req_addr,
    output imem_i_req_ready, imem_i_rsp_valid, imem_i_rsp_inst
  );
endinterface

// File: rtl/fetch_buf.sv
// Two-entry {pc, inst} FIFO with flush; slot 0 is always the head.
module fetch_buf
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t slot_q [2];
  logic [1:0]   count_q;
  logic         wr_idx;

  always_comb begin
    wr_idx = pop ? 1'(count_q - 2'd1) : 1'(count_q);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  // Pop shifts slot 1 forward; a simultaneous push lands behind the survivor.
  always_ff @(posedge clk) begin
    if (pop) slot_q[0] <= slot_q[1];
    if (push) slot_q[wr_idx] <= push_data;
  end

  assign head  = slot_q[0];
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: issues sequential imem requests, buffers in-order responses and
// drops stale ones by epoch. Define FETCH_STATIC_PRED_EN for backward-branch prediction.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ctrl_i_regF_stall,
  input  logic                execute_i_branch_fix,
  input  logic [31:0]         execute_i_fix_pc,
  fetch_stage_if.master       imem,
  output logic                fetch_o_valid,
  output logic [31:0]         fetch_o_pc,
  output logic [31:0]         fetch_o_inst,
  output logic                fetch_o_pred_taken
);

`ifdef FETCH_STATIC_PRED_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic [31:0]  pc_q;
  logic         epoch_q;
  logic [1:0]   out_q;
  logic [1:0]   tag_q;

  fetch_entry_t head;
  fetch_entry_t rsp_entry;
  logic [1:0]   buf_count;
  logic         buf_valid;
  logic         deq;
  logic         back_branch;
  logic [31:0]  bimm;
  logic         pred_redirect;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         req_valid_c;
  logic         accept;
  logic         rsp_fire;
  logic         buf_push;
  logic [1:0]   out_nxt;
  logic [1:0]   tag_nxt;

  always_comb begin
    buf_valid     = buf_count != 2'd0;
    deq           = buf_valid && !ctrl_i_regF_stall;
    back_branch   = (head.inst[OPC_MSB:OPC_LSB] == OPCODE_BRANCH) && head.inst[BIMM_SIGN];
    bimm          = {{20{head.inst[BIMM_SIGN]}}, head.inst[BIMM_B11],
                     head.inst[BIMM_HI_MSB:BIMM_HI_LSB], head.inst[BIMM_LO_MSB:BIMM_LO_LSB], 1'b0};
    pred_redirect = PRED_EN && deq && back_branch && !execute_i_branch_fix;
    redirect      = execute_i_branch_fix || pred_redirect;
    redirect_pc   = execute_i_branch_fix ? execute_i_fix_pc : head.pc + bimm;
    req_valid_c   = !rst && !redirect && ((3'(out_q) + 3'(buf_count)) < 3'd2);
    accept        = req_valid_c && imem.imem_i_req_ready;
    // Responses with nothing outstanding belong to pre-reset requests.
    rsp_fire      = imem.imem_i_rsp_valid && (out_q != 2'd0);
    buf_push      = rsp_fire && (tag_q[0] == epoch_q) && !redirect;
    // Current-epoch requests are contiguous from pc_q backwards, so the oldest is pc_q - 4*out.
    rsp_entry.pc   = pc_q - 32'({out_q, 2'b00});
    rsp_entry.inst = imem.imem_i_rsp_inst;
    out_nxt       = out_q + 2'(accept) - 2'(rsp_fire);
    tag_nxt       = rsp_fire ? {1'b0, tag_q[1]} : tag_q;
    if (accept) tag_nxt[1'(out_q - 2'(rsp_fire))] = epoch_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      epoch_q <= 1'b0;
      out_q   <= 2'd0;
      tag_q   <= 2'd0;
    end else begin
      out_q <= out_nxt;
      tag_q <= tag_nxt;
      if (redirect) begin
        pc_q    <= redirect_pc;
        epoch_q <= ~epoch_q;
      end else if (accept) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (buf_push),
    .pop       (deq),
    .push_data (rsp_entry),
    .head      (head),
    .count     (buf_count)
  );

  assign imem.fetch_o_req_valid = req_valid_c;
  assign imem.fetch_o_req_addr  = pc_q;
  assign fetch_o_valid          = buf_valid;
  assign fetch_o_pc             = head.pc;
  assign fetch_o_inst           = head.inst;
  assign fetch_o_pred_taken     = PRED_EN && buf_valid && back_branch;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// against a queue-based reference model and a latency-modelled imem.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] BEQ_M16 = 32'hFE00_08E3;
`ifdef FETCH_STATIC_PRED_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, fix;
  logic [31:0] fix_pc;
  logic        o_valid, o_pred;
  logic [31:0] o_pc, o_inst;

  fetch_stage_if imem_if ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ctrl_i_regF_stall    (stall),
    .execute_i_branch_fix (fix),
    .execute_i_fix_pc     (fix_pc),
    .imem                 (imem_if),
    .fetch_o_valid        (o_valid),
    .fetch_o_pc           (o_pc),
    .fetch_o_inst         (o_inst),
    .fetch_o_pred_taken   (o_pred)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // imem environment
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  bit          rsp_hold;
  int          lat_max;
  int          last_due;
  logic [31:0] beq_addr;

  // reference model: outstanding requests tagged by redirect generation, buffered entries
  logic [31:0] m_out_addr [$];
  int          m_out_gen  [$];
  logic [31:0] m_buf_pc   [$];
  logic [31:0] m_buf_inst [$];
  logic [31:0] m_req_pc;
  int          m_gen;

  logic [31:0] acc_log  [$];
  logic [31:0] deq_log  [$];
  logic [31:0] pred_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    logic [31:0] h;
    if (a == beq_addr) return BEQ_M16;
    h = a * 32'h9E37_79B1;
    return {h[31:7], 7'h13};
  endfunction

  function automatic bit back_branch(input logic [31:0] i);
    return (i[6:0] == 7'h63) && i[31];
  endfunction

  function automatic logic [31:0] b_target(input logic [31:0] pc, input logic [31:0] i);
    logic signed [12:0] imm;
    imm = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    return pc + 32'(imm);
  endfunction

  function automatic bit no_stale();
    foreach (m_out_gen[i]) if (m_out_gen[i] != m_gen) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive imem response, check outputs against model, then advance both.
  task automatic cycle();
    bit          rsp_v, deq, pred, redir, e_rv, acc_m, acc_d;
    logic [31:0] rsp_inst, d_addr, hp, hi, a;
    int          g, due;
    rsp_v    = !rsp_hold && pend_addr.size() > 0 && pend_due[0] <= cyc;
    rsp_inst = rsp_v ? inst_of(pend_addr[0]) : $urandom;
    imem_if.imem_i_rsp_valid = rsp_v;
    imem_if.imem_i_rsp_inst  = rsp_inst;
    #1;
    hp    = m_buf_pc.size() > 0 ? m_buf_pc[0] : 32'h0;
    hi    = m_buf_inst.size() > 0 ? m_buf_inst[0] : 32'h0;
    deq   = !rst && m_buf_pc.size() > 0 && !stall;
    pred  = PRED && deq && back_branch(hi) && !fix;
    redir = !rst && (fix || pred);
    e_rv  = !rst && !redir && (m_out_addr.size() + m_buf_pc.size() < 2);
    check("req_valid", 32'(imem_if.fetch_o_req_valid), 32'(e_rv));
    if (e_rv) check("req_addr", imem_if.fetch_o_req_addr, m_req_pc);
    if (!rst) begin
      check("out_valid", 32'(o_valid), 32'(m_buf_pc.size() > 0));
      if (m_buf_pc.size() > 0) begin
        check("out_pc", o_pc, hp);
        check("out_inst", o_inst, hi);
        check("out_pred", 32'(o_pred), 32'(PRED && back_branch(hi)));
      end else begin
        check("out_pred_idle", 32'(o_pred), 32'h0);
      end
      if (o_valid === 1'b1 && !stall) begin
        deq_log.push_back(o_pc);
        pred_log.push_back(32'(o_pred));
      end
    end
    acc_m  = e_rv && imem_if.imem_i_req_ready;
    acc_d  = (imem_if.fetch_o_req_valid === 1'b1) && imem_if.imem_i_req_ready;
    d_addr = imem_if.fetch_o_req_addr;
    if (acc_d) acc_log.push_back(d_addr);
    @(posedge clk);
    if (rsp_v) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (acc_d) begin
      due = cyc + int'($urandom_range(lat_max, 1));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(d_addr);
      pend_due.push_back(due);
    end
    if (rst) begin
      m_out_addr.delete(); m_out_gen.delete();
      m_buf_pc.delete(); m_buf_inst.delete();
      m_req_pc = RST_PC;
      m_gen++;
    end else begin
      if (rsp_v && m_out_addr.size() > 0) begin
        a = m_out_addr.pop_front();
        g = m_out_gen.pop_front();
        if (g == m_gen && !redir) begin
          m_buf_pc.push_back(a);
          m_buf_inst.push_back(rsp_inst);
        end
      end
      if (deq) begin
        void'(m_buf_pc.pop_front());
        void'(m_buf_inst.pop_front());
      end
      if (redir) begin
        m_buf_pc.delete(); m_buf_inst.delete();
        m_req_pc = fix ? fix_pc : b_target(hp, hi);
        m_gen++;
      end else if (acc_m) begin
        m_out_addr.push_back(m_req_pc);
        m_out_gen.push_back(m_gen);
        m_req_pc = m_req_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    acc_log.delete(); deq_log.delete(); pred_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; fix = 1'b0; rsp_hold = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    pend_addr.delete(); pend_due.delete();
    last_due = cyc;
    clear_logs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int held, k;
    logic [31:0] hold_pc, hold_inst;
    stall = 1'b0; fix = 1'b0; fix_pc = 32'h0;
    imem_if.imem_i_req_ready = 1'b0;
    imem_if.imem_i_rsp_valid = 1'b0;
    imem_if.imem_i_rsp_inst  = 32'h0;
    rsp_hold = 1'b0; lat_max = 1; last_due = 0; beq_addr = 32'h0;
    m_req_pc = RST_PC; m_gen = 0;
    @(negedge clk);
    do_reset();
    #1;
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_pred", 32'(o_pred), 32'h0);
    check("rst_req_valid", 32'(imem_if.fetch_o_req_valid), 32'h1);
    check("rst_req_addr", imem_if.fetch_o_req_addr, RST_PC);

    // sequential fetch, ready=1, 1-cycle responses
    imem_if.imem_i_req_ready = 1'b1;
    repeat (12) cycle();
    check("seq_req0", q_at(acc_log, 0), 32'h8000_0000);
    check("seq_req1", q_at(acc_log, 1), 32'h8000_0004);
    for (int i = 0; i < 4; i++) check($sformatf("seq_out%0d", i), q_at(deq_log, i), RST_PC + 32'(4 * i));

    // stall with both buffer entries full
    stall = 1'b1;
    for (int i = 0; i < 20 && m_buf_pc.size() < 2; i++) cycle();
    check("stall_full", 32'(o_valid), 32'h1);
    hold_pc   = m_buf_pc.size() > 0 ? m_buf_pc[0] : 32'h0;
    hold_inst = m_buf_inst.size() > 0 ? m_buf_inst[0] : 32'h0;
    repeat (3) begin
      cycle();
      check("stall_req_off", 32'(imem_if.fetch_o_req_valid), 32'h0);
      check("stall_pc_hold", o_pc, hold_pc);
      check("stall_inst_hold", o_inst, hold_inst);
    end
    stall = 1'b0;
    clear_logs();
    repeat (10) cycle();
    for (int i = 0; i < 4; i++) check($sformatf("stall_resume%0d", i), q_at(deq_log, i), hold_pc + 32'(4 * i));

    // branch_fix with two requests outstanding
    do_reset();
    imem_if.imem_i_req_ready = 1'b1;
    rsp_hold = 1'b1;
    for (int i = 0; i < 10 && m_out_addr.size() < 2; i++) cycle();
    check("fix_two_out", 32'(imem_if.fetch_o_req_valid), 32'h0);
    fix = 1'b1; fix_pc = 32'h8000_0100;
    cycle();
    fix = 1'b0; rsp_hold = 1'b0;
    clear_logs();
    for (int i = 0; i < 30 && deq_log.size() < 2; i++) cycle();
    check("fix_out0", q_at(deq_log, 0), 32'h8000_0100);
    check("fix_out1", q_at(deq_log, 1), 32'h8000_0104);

    // imem not ready: address held, no PC increment
    do_reset();
    imem_if.imem_i_req_ready = 1'b1;
    for (int i = 0; i < 10 && acc_log.size() < 2; i++) cycle();
    imem_if.imem_i_req_ready = 1'b0;
    held = 0;
    repeat (6) begin
      cycle();
      if (imem_if.fetch_o_req_valid === 1'b1) begin
        held++;
        check("nready_addr_hold", imem_if.fetch_o_req_addr, 32'h8000_0008);
      end
    end
    check("nready_held_cycles", 32'(held >= 4), 32'h1);
    imem_if.imem_i_req_ready = 1'b1;
    repeat (4) cycle();
    check("nready_req2", q_at(acc_log, 2), 32'h8000_0008);
    check("nready_req3", q_at(acc_log, 3), 32'h8000_000C);

    // backward beq at 0x80000010, imm = -16
    do_reset();
    beq_addr = 32'h8000_0010;
    imem_if.imem_i_req_ready = 1'b1;
    repeat (40) cycle();
    k = -1;
    foreach (deq_log[i]) if (k < 0 && deq_log[i] == 32'h8000_0010) k = i;
    check("beq_seen", 32'(k >= 0), 32'h1);
    check("beq_pred", q_at(pred_log, k), 32'(PRED));
    check("beq_next", q_at(deq_log, k + 1), PRED ? 32'h8000_0000 : 32'h8000_0014);
    beq_addr = 32'h0;

    // reset with two requests outstanding; late responses must be ignored
    do_reset();
    imem_if.imem_i_req_ready = 1'b1;
    rsp_hold = 1'b1;
    for (int i = 0; i < 10 && m_out_addr.size() < 2; i++) cycle();
    rst = 1'b1; rsp_hold = 1'b0;
    cycle();
    rst = 1'b0;
    clear_logs();
    for (int i = 0; i < 30 && deq_log.size() < 2; i++) cycle();
    check("rstout_req0", q_at(acc_log, 0), RST_PC);
    check("rstout_out0", q_at(deq_log, 0), RST_PC);
    check("rstout_out1", q_at(deq_log, 1), RST_PC + 32'd4);

    // randomized traffic
    do_reset();
    lat_max = 3;
    repeat (3000) begin
      stall = ($urandom_range(9, 0) < 3);
      imem_if.imem_i_req_ready = ($urandom_range(9, 0) < 7);
      fix = 1'b0;
      if ($urandom_range(49, 0) == 0 && no_stale()) begin
        fix    = 1'b1;
        fix_pc = RST_PC + (32'($urandom_range(255, 0)) << 2);
      end
      cycle();
    end
    fix = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
